// File: rtl/data_ram_ctrl.sv
// Multi-cycle data-memory responder for the CPU load/store port.
// Each transaction is latched once and passes through optional wait states.
// It then commits a byte-masked write or returns the addressed word, and
// completes with a one-cycle registered ack. Misaligned or out-of-range
// requests ack with err set and leave memory untouched.
module data_ram_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ram_ce_i,
    input  logic        data_ram_we_i,
    input  logic [31:0] data_ram_addr_i,
    input  logic [3:0]  data_ram_sel_i,
    input  logic [31:0] data_ram_data_i,
    output logic [31:0] data_ram_data_o,
    output logic        data_ram_ack_o,
    output logic        data_ram_err_o
);

    localparam int unsigned Depth    = 1 << ADDR_WIDTH;
    localparam logic [2:0]  CntInit  = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem_q [Depth];

    // Effective request: the live inputs while idle (needed when WAIT_CYCLES
    // is 0 and the request commits on its sampling edge), else the latched copy.
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [3:0]            req_sel;
    logic [31:0]           req_wdata;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  req_err;
    logic                  enter_ack;
    logic                  mem_we;
    logic [31:0]           mem_wdata;

    // Select the request being served and decode its error condition.
    always_comb begin
        if (state_q == StIdle) begin
            req_we    = data_ram_we_i;
            req_addr  = data_ram_addr_i;
            req_sel   = data_ram_sel_i;
            req_wdata = data_ram_data_i;
        end else begin
            req_we    = we_q;
            req_addr  = addr_q;
            req_sel   = sel_q;
            req_wdata = wdata_q;
        end
        req_idx = req_addr[ADDR_WIDTH+1:2];
        req_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    end

    // Next-state logic for the IDLE -> WAIT -> ACK sequence and request latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        wdata_d   = wdata_q;
        enter_ack = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (data_ram_ce_i) begin
                    we_d    = data_ram_we_i;
                    addr_d  = data_ram_addr_i;
                    sel_d   = data_ram_sel_i;
                    wdata_d = data_ram_data_i;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = StAck;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    state_d   = StAck;
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Registered response and byte-lane merge for the write commit.
    always_comb begin
        ack_d     = enter_ack;
        err_d     = enter_ack && req_err;
        rdata_d   = rdata_q;
        mem_we    = enter_ack && req_we && !req_err;
        mem_wdata = mem_q[req_idx];
        for (int b = 0; b < 4; b++) begin
            if (req_sel[b]) begin
                mem_wdata[8*b +: 8] = req_wdata[8*b +: 8];
            end
        end
        if (enter_ack) begin
            if (req_err) begin
                rdata_d = 32'd0;
            end else if (!req_we) begin
                rdata_d = mem_q[req_idx];
            end
        end
    end

    // State and output registers; memory is never reset but cannot be written
    // while reset is held, so an aborted transaction leaves no trace.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            sel_q   <= 4'd0;
            wdata_q <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (mem_we) begin
                mem_q[req_idx] <= mem_wdata;
            end
        end
    end

    assign data_ram_data_o = rdata_q;
    assign data_ram_ack_o  = ack_q;
    assign data_ram_err_o  = err_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Bench for data_ram_ctrl: three instances (0, 1 and 3 wait states) share one
// stimulus stream; a timestamp-based transaction model predicts ack/err/data.
module tb_data_ram_ctrl;

    localparam int unsigned AW = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] dout [3];
    logic        ack  [3];
    logic        err  [3];

    always #5 clk = ~clk;

    data_ram_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .data_ram_ce_i(ce), .data_ram_we_i(we),
        .data_ram_addr_i(addr), .data_ram_sel_i(sel), .data_ram_data_i(wdata),
        .data_ram_data_o(dout[0]), .data_ram_ack_o(ack[0]), .data_ram_err_o(err[0])
    );
    data_ram_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .data_ram_ce_i(ce), .data_ram_we_i(we),
        .data_ram_addr_i(addr), .data_ram_sel_i(sel), .data_ram_data_i(wdata),
        .data_ram_data_o(dout[1]), .data_ram_ack_o(ack[1]), .data_ram_err_o(err[1])
    );
    data_ram_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(3)) u_dut2 (
        .clk(clk), .rst(rst), .data_ram_ce_i(ce), .data_ram_we_i(we),
        .data_ram_addr_i(addr), .data_ram_sel_i(sel), .data_ram_data_i(wdata),
        .data_ram_data_o(dout[2]), .data_ram_ack_o(ack[2]), .data_ram_err_o(err[2])
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // ---------------- reference model ----------------
    int          wc_of   [3] = '{0, 1, 3};
    int          edge_n      = 0;
    int          free_at [3] = '{0, 0, 0};
    int          done_at [3] = '{-1, -1, -1};
    logic        l_we    [3];
    logic [31:0] l_addr  [3];
    logic [31:0] l_wd    [3];
    logic [3:0]  l_sel   [3];
    logic [31:0] mmem    [3][16];
    logic        exp_ack [3] = '{0, 0, 0};
    logic        exp_err [3] = '{0, 0, 0};
    logic [31:0] exp_data[3] = '{0, 0, 0};

    function automatic logic is_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
    endfunction

    task automatic complete(input int k);
        logic [3:0] idx;
        idx        = l_addr[k][5:2];
        exp_ack[k] = 1'b1;
        if (is_err(l_addr[k])) begin
            exp_err[k]  = 1'b1;
            exp_data[k] = 32'd0;
        end else if (l_we[k]) begin
            for (int b = 0; b < 4; b++)
                if (l_sel[k][b]) mmem[k][idx][8*b +: 8] = l_wd[k][8*b +: 8];
        end else begin
            exp_data[k] = mmem[k][idx];
        end
        free_at[k] = edge_n + 2;
        done_at[k] = -1;
    endtask

    always @(posedge clk) begin
        edge_n++;
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                exp_ack[k]  = 1'b0;
                exp_err[k]  = 1'b0;
                exp_data[k] = 32'd0;
                done_at[k]  = -1;
                free_at[k]  = 0;
            end else begin
                exp_ack[k] = 1'b0;
                exp_err[k] = 1'b0;
                if (done_at[k] == edge_n) begin
                    complete(k);
                end else if (done_at[k] < 0 && edge_n >= free_at[k] && ce) begin
                    l_we[k]   = we;
                    l_addr[k] = addr;
                    l_sel[k]  = sel;
                    l_wd[k]   = wdata;
                    if (wc_of[k] == 0) complete(k);
                    else done_at[k] = edge_n + wc_of[k];
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                check($sformatf("rst_ack%0d", k), 32'(ack[k]), 32'd0);
                check($sformatf("rst_err%0d", k), 32'(err[k]), 32'd0);
                check($sformatf("rst_data%0d", k), dout[k], 32'd0);
            end else begin
                check($sformatf("ack%0d", k), 32'(ack[k]), 32'(exp_ack[k]));
                check($sformatf("err%0d", k), 32'(err[k]), 32'(exp_err[k]));
                check($sformatf("data%0d", k), dout[k], exp_data[k]);
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    int          got_cyc  [3];
    logic        got_err  [3];
    logic [31:0] got_data [3];

    // One-cycle request, then inputs scrambled with ce low; records each ack.
    task automatic xact(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d);
        @(posedge clk); #1;
        ce = 1'b1; we = w; addr = a; sel = s; wdata = d;
        for (int k = 0; k < 3; k++) got_cyc[k] = -1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                ce = 1'b0; we = ~w; addr = $urandom; sel = 4'($urandom); wdata = $urandom;
            end
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (ack[k] && got_cyc[k] < 0) begin
                    got_cyc[k]  = c;
                    got_err[k]  = err[k];
                    got_data[k] = dout[k];
                end
            end
        end
    endtask

    initial begin
        int n;
        int q[$];
        logic [3:0] w4;
        logic [1:0] lo;
        int r;

        rst = 1'b0; ce = 1'b0; we = 1'b0; addr = 32'd0; sel = 4'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("post_rst_ack", 32'(ack[k]), 32'd0);
            check("post_rst_data", dout[k], 32'd0);
        end
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack[0] || ack[1] || ack[2]) n++;
        end
        check("idle_no_ack", 32'(n), 32'd0);

        for (int i = 0; i < 16; i++) xact(1'b1, 32'(i * 4), 4'hF, {16'hC0DE, 16'(i)});

        xact(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        check("wr_cyc_ws0", 32'(got_cyc[0]), 32'd1);
        check("wr_cyc_ws1", 32'(got_cyc[1]), 32'd2);
        check("wr_cyc_ws3", 32'(got_cyc[2]), 32'd4);
        check("wr_err", 32'(got_err[1]), 32'd0);
        xact(1'b0, 32'h10, 4'h0, 32'h0);
        check("rd_data_ws1", got_data[1], 32'hDEADBEEF);
        check("rd_data_ws0", got_data[0], 32'hDEADBEEF);

        xact(1'b1, 32'h20, 4'hF, 32'h11223344);
        xact(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
        xact(1'b0, 32'h20, 4'hF, 32'h0);
        check("lane_merge", got_data[1], 32'h11BB33DD);
        xact(1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF);
        check("sel0_ack", 32'(got_cyc[1]), 32'd2);
        check("sel0_err", 32'(got_err[1]), 32'd0);
        xact(1'b0, 32'h20, 4'hF, 32'h0);
        check("sel0_unchanged", got_data[2], 32'h11BB33DD);

        xact(1'b0, 32'h22, 4'hF, 32'h0);
        check("misalign_err", 32'(got_err[1]), 32'd1);
        check("misalign_data", got_data[1], 32'd0);
        xact(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF);
        check("range_err", 32'(got_err[1]), 32'd1);
        xact(1'b0, 32'h0, 4'hF, 32'h0);
        check("word0_kept", got_data[1], 32'hC0DE0000);

        // ce held high across three back-to-back requests
        @(posedge clk); #1;
        ce = 1'b1; we = 1'b0; addr = 32'h10; sel = 4'hF;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            if (c == 9) ce = 1'b0;
            @(negedge clk);
            if (ack[1]) q.push_back(c);
        end
        check("held_n", 32'(q.size()), 32'd3);
        for (int i = 0; i < q.size() && i < 3; i++) check("held_cyc", 32'(q[i]), 32'(2 + 3 * i));
        repeat (6) @(posedge clk);

        // reset while the 3-wait-state instance is still waiting
        @(posedge clk); #1;
        ce = 1'b1; we = 1'b1; addr = 32'h30; sel = 4'hF; wdata = 32'h12345678;
        n = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) ce = 1'b0;
            if (c == 2) rst = 1'b0;
            if (c == 3) rst = 1'b1;
            @(negedge clk);
            if (ack[2]) n++;
        end
        check("abort_no_ack", 32'(n), 32'd0);
        xact(1'b0, 32'h30, 4'hF, 32'h0);
        check("abort_kept", got_data[2], 32'hC0DE000C);
        check("ws0_committed", got_data[0], 32'h12345678);

        // randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            rst   = (!rst) ? 1'b1 : ($urandom_range(63) != 0);
            ce    = 1'($urandom_range(1));
            we    = 1'($urandom_range(1));
            sel   = 4'($urandom);
            wdata = $urandom;
            w4    = 4'($urandom_range(15));
            lo    = 2'($urandom_range(1, 3));
            r     = $urandom_range(9);
            if (r < 8)       addr = {26'd0, w4, 2'b00};
            else if (r == 8) addr = {26'd0, w4, lo};
            else             addr = {20'($urandom_range(1, 1048575)), 6'd0, w4, 2'b00};
        end
        @(posedge clk); #1;
        rst = 1'b1; ce = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
